// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and default width for the mul/div unit
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - operand sign/magnitude extraction and signed result fix-up/select
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               a_neg_o,
    output logic               b_neg_o,
    output logic [WIDTH-1:0]   a_mag_o,
    output logic [WIDTH-1:0]   b_mag_o,
    input  logic [2:0]         res_op_i,
    input  logic               res_a_neg_i,
    input  logic               res_b_neg_i,
    input  logic [2*WIDTH-1:0] acc_i,
    output logic [WIDTH-1:0]   res_o
);

    logic               a_signed;
    logic               b_signed;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    assign a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
    assign b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    assign a_neg_o  = a_signed & a_i[WIDTH-1];
    assign b_neg_o  = b_signed & b_i[WIDTH-1];
    assign a_mag_o  = a_neg_o ? -a_i : a_i;
    assign b_mag_o  = b_neg_o ? -b_i : b_i;

    // Multiply uses the full product; divide keeps remainder high, quotient low
    assign prod_fix = (res_a_neg_i ^ res_b_neg_i) ? -acc_i : acc_i;
    assign quot     = acc_i[WIDTH-1:0];
    assign rem      = acc_i[2*WIDTH-1:WIDTH];

    always_comb begin
        res_o = '0;
        case (res_op_i)
            OP_MUL:                       res_o = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res_o = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              res_o = (res_a_neg_i ^ res_b_neg_i) ? -quot : quot;
            default:                      res_o = res_a_neg_i ? -rem : rem;
        endcase
    end

endmodule

// File: rtl/module_muldiv_unit.sv
// rtl/module_muldiv_unit.sv - iterative RV32M mul/div unit; MULDIV_EARLY_OUT_EN enables special-case early-out
module module_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2:0]         op_q, op_d;
    logic               a_neg_q, a_neg_d, b_neg_q, b_neg_d;
    logic               spec_q, spec_d;
    logic [WIDTH-1:0]   spec_val_q, spec_val_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   fixed_res;
    logic               accept;
    logic               div_zero, div_ovf, mul_zero, spec_now;
    logic [WIDTH-1:0]   spec_val_now;
    logic [WIDTH:0]     mul_sum, div_shift, div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] iter_next;

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .op_i        (op),
        .a_i         (operand_a),
        .b_i         (operand_b),
        .a_neg_o     (a_neg),
        .b_neg_o     (b_neg),
        .a_mag_o     (a_mag),
        .b_mag_o     (b_mag),
        .res_op_i    (op_q),
        .res_a_neg_i (a_neg_q),
        .res_b_neg_i (b_neg_q),
        .acc_i       (iter_next),
        .res_o       (fixed_res)
    );

    assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign div_zero = op[2] && (operand_b == '0);
    assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (operand_a == MIN_NEG) && (operand_b == '1);
    assign mul_zero = !op[2] && ((operand_a == '0) || (operand_b == '0));
    assign spec_now = div_zero || div_ovf || mul_zero;
    assign spec_val_now = div_zero ? (op[1] ? operand_a : '1) :
                          div_ovf  ? (op[1] ? '0 : MIN_NEG) : '0;

    // Multiply: add multiplicand into the high half, shift right; divide: restoring shift-subtract
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_sub   = div_shift - {1'b0, opnd_q};
    assign iter_next = (state_q == S_DIV)
                     ? {(div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge}
                     : {mul_sum, acc_q[WIDTH-1:1]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        op_d       = op_q;
        a_neg_d    = a_neg_q;
        b_neg_d    = b_neg_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        result_d   = result_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    op_d       = op;
                    a_neg_d    = a_neg;
                    b_neg_d    = b_neg;
                    spec_d     = spec_now;
                    spec_val_d = spec_val_now;
                    cnt_d      = CW'(WIDTH - 1);
                    state_d    = op[2] ? S_DIV : S_MUL;
                    acc_d      = {{WIDTH{1'b0}}, (op[2] ? a_mag : b_mag)};
                    opnd_d     = op[2] ? b_mag : a_mag;
`ifdef MULDIV_EARLY_OUT_EN
                    if (spec_now) begin
                        state_d  = S_DONE;
                        result_d = spec_val_now;
                    end
`endif
                end
            end
            S_MUL, S_DIV: begin
                acc_d = iter_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    result_d = spec_q ? spec_val_q : fixed_res;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            op_q       <= '0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            op_q       <= op_d;
            a_neg_q    <= a_neg_d;
            b_neg_q    <= b_neg_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            result_q   <= result_d;
        end
    end

    assign busy   = (state_q == S_MUL) || (state_q == S_DIV);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_module_muldiv_unit.sv
// tb/tb_module_muldiv_unit.sv - self-checking bench for module_muldiv_unit
module tb_module_muldiv_unit;

    localparam logic [31:0] MIN = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        busy, done;
    logic [31:0] result;

    int passed = 0;
    int total  = 0;

    module_muldiv_unit dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (o[2] && b == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == MIN && b == 32'hFFFF_FFFF) return 1;
        if (!o[2] && (a == 0 || b == 0)) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return MIN;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called just after a falling edge; returns at the falling edge of cycle 1
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(negedge clock);
        start = 1'b0; op = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
    endtask

    task automatic wait_done(input string tag, input logic [31:0] exp, input int lat, input int inject_at);
        int c = 1;
        logic busy_bad = 1'b0;
        while (done !== 1'b1 && c < 200) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            start = (c == inject_at);
            if (c == inject_at) begin op = 3'd0; operand_a = 32'd3; operand_b = 32'd3; end
            @(negedge clock);
            c++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(c), 32'(lat));
        check({tag, "_busy_while_iterating"}, {31'b0, busy_bad}, 32'h0);
        check({tag, "_busy_at_done"}, {31'b0, busy}, 32'h0);
        check({tag, "_result"}, result, exp);
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        issue(o, a, b);
        wait_done(tag, exp, exp_lat(o, a, b), -1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        logic        seen;

        repeat (3) @(negedge clock);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_result", result, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        run("mul",       3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run("mulh",      3'd1, MIN,          MIN,           32'h4000_0000);
        run("mulhu",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run("div_neg",   3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD);
        run("rem_neg",   3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF);
        run("divu",      3'd5, 32'd100,      32'd7,         32'd14);
        run("remu",      3'd7, 32'd100,      32'd7,         32'd2);
        run("div_by0",   3'd4, 32'd5,        32'd0,         32'hFFFF_FFFF);
        run("rem_by0",   3'd6, 32'd5,        32'd0,         32'd5);
        run("divu_by0",  3'd5, 32'd9,        32'd0,         32'hFFFF_FFFF);
        run("remu_by0",  3'd7, 32'd9,        32'd0,         32'd9);
        run("div_ovf",   3'd4, MIN,          32'hFFFF_FFFF, MIN);
        run("rem_ovf",   3'd6, MIN,          32'hFFFF_FFFF, 32'h0);
        run("mul_zero",  3'd0, 32'd0,        32'd1234,      32'h0);

        @(negedge clock);
        check("idle_done_low", {31'b0, done}, 32'h0);
        check("idle_busy_low", {31'b0, busy}, 32'h0);

        issue(3'd5, 32'd100, 32'd7);
        wait_done("ignored_start", 32'd14, 33, 5);

        run("b2b_first",  3'd5, 32'd100, 32'd7, 32'd14);
        run("b2b_second", 3'd0, 32'd6,   32'd7, 32'd42);

        @(negedge clock);
        issue(3'd0, 32'd5, 32'd6);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_done", {31'b0, done}, 32'h0);
        check("abort_result", result, 32'h0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1) seen = 1'b1;
        end
        check("abort_no_done", {31'b0, seen}, 32'h0);
        run("after_abort", 3'd7, 32'd1000, 32'd33, 32'd10);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom);
            ra = pick();
            rb = pick();
            if ($urandom_range(0, 1) == 1) @(negedge clock);
            run($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, model(ro, ra, rb));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
